// File: rtl/processor_pkg.sv
// Shared ISA constants, decoded-control types and small helpers for the single-cycle core.
// Latency: n/a (package only).
// Backpressure: n/a.
package processor_pkg;

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Memory / jump funct3
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

    typedef struct packed {
        alu_op_t  alu_op;
        logic     a_pc;     // ALU operand A is pc (auipc)
        logic     b_imm;    // ALU operand B is the immediate
        imm_sel_t imm_sel;
        logic     reg_we;
        logic     mem_we;
        wb_sel_t  wb_sel;
        logic     branch;
        logic     jal;
        logic     jalr;
    } ctrl_t;

    // R-type and I-type ALU ops share the funct3 map; alt selects sub/sra.
    function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic t;
        case (f3)
            F3_BEQ:  t = (a == b);
            F3_BNE:  t = (a != b);
            F3_BLT:  t = ($signed(a) < $signed(b));
            F3_BGE:  t = ($signed(a) >= $signed(b));
            F3_BLTU: t = (a < b);
            F3_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU; shift amounts use b[4:0] only.
// Latency: combinational. Backpressure: none.
// Ports: a, b, op -> y.
module alu
    import processor_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] y
);
    always_comb begin
        case (op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_AND:    y = a & b;
            ALU_OR:     y = a | b;
            ALU_XOR:    y = a ^ b;
            ALU_SLL:    y = a << b[4:0];
            ALU_SRL:    y = a >> b[4:0];
            ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:    y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:   y = {31'd0, a < b};
            ALU_PASS_B: y = b;
            default:    y = a + b;
        endcase
    end
endmodule

// File: rtl/data_mem.sv
// Word-addressed data RAM, combinational read, write on clk edge.
// Latency: read 0 cycles, write 1 cycle. Backpressure: none.
// Ports: addr -> rdat; we/wdat write at addr.
module data_mem #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [31:0]              rdat,
    input  logic                     we,
    input  logic [31:0]              wdat
);
    logic [31:0] mem [0:DEPTH-1];

    assign rdat = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdat;
    end
endmodule

// File: rtl/decoder.sv
// Instruction decoder; anything unsupported decodes to all-zero control (a NOP that falls through to pc+4).
// Latency: combinational. Backpressure: none.
// Ports: opcode/funct3/funct7 -> ctrl.
module decoder
    import processor_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl
);
    logic alt;
    assign alt = (funct7 == F7_ALT);

    always_comb begin
        ctrl         = '0;
        ctrl.alu_op  = ALU_ADD;
        ctrl.imm_sel = IMM_I;
        ctrl.wb_sel  = WB_ALU;
        case (opcode)
            OP_R: begin
                // funct7=0x20 is only legal for sub and sra.
                if (funct7 == F7_BASE || (alt && (funct3 == F3_ADD || funct3 == F3_SR))) begin
                    ctrl.alu_op = alu_op_from_f3(funct3, alt);
                    ctrl.reg_we = 1'b1;
                end
            end
            OP_I: begin
                // For shifts, funct7 occupies imm[11:5] and must be a legal encoding.
                if ((funct3 != F3_SLL || funct7 == F7_BASE) &&
                    (funct3 != F3_SR || funct7 == F7_BASE || alt)) begin
                    ctrl.alu_op = alu_op_from_f3(funct3, (funct3 == F3_SR) && alt);
                    ctrl.b_imm  = 1'b1;
                    ctrl.reg_we = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_W) begin
                    ctrl.b_imm  = 1'b1;
                    ctrl.reg_we = 1'b1;
                    ctrl.wb_sel = WB_MEM;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_W) begin
                    ctrl.b_imm   = 1'b1;
                    ctrl.imm_sel = IMM_S;
                    ctrl.mem_we  = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 != F3_SLT && funct3 != F3_SLTU) begin
                    ctrl.branch  = 1'b1;
                    ctrl.imm_sel = IMM_B;
                end
            end
            OP_JAL: begin
                ctrl.jal     = 1'b1;
                ctrl.imm_sel = IMM_J;
                ctrl.reg_we  = 1'b1;
                ctrl.wb_sel  = WB_PC4;
            end
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    ctrl.jalr   = 1'b1;
                    ctrl.b_imm  = 1'b1;
                    ctrl.reg_we = 1'b1;
                    ctrl.wb_sel = WB_PC4;
                end
            end
            OP_LUI: begin
                ctrl.alu_op  = ALU_PASS_B;
                ctrl.b_imm   = 1'b1;
                ctrl.imm_sel = IMM_U;
                ctrl.reg_we  = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.a_pc    = 1'b1;
                ctrl.b_imm   = 1'b1;
                ctrl.imm_sel = IMM_U;
                ctrl.reg_we  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/imm_gen.sv
// Sign-extended immediate for the I/S/B/U/J instruction formats.
// Latency: combinational. Backpressure: none.
// Ports: inst[31:7] + sel -> imm.
module imm_gen
    import processor_pkg::*;
(
    input  logic [31:7] inst,
    input  imm_sel_t    sel,
    output logic [31:0] imm
);
    always_comb begin
        case (sel)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'd0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end
endmodule

// File: rtl/inst_mem.sv
// Instruction ROM, combinational read; load port exists only to give the array a driver.
// Latency: read 0 cycles, load 1 cycle. Backpressure: none.
// Ports: addr -> dat (word read); load_en/load_addr/load_dat (tied off in the core).
module inst_mem #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [31:0]              dat,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_dat
);
    logic [31:0] mem [0:DEPTH-1];

    assign dat = mem[addr];

    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_dat;
    end
endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file, two combinational read ports, one write port; x0 reads zero.
// Latency: read 0 cycles, write lands on the clk edge. Backpressure: none.
// Ports: rs1_addr/rs2_addr -> rs1_dat/rs2_dat; we/rd_addr/rd_dat write port.
module reg_file (
    input  logic        clk,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_dat,
    output logic [31:0] rs2_dat,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_dat
);
    // Contents are deliberately not reset so preloaded values survive reset.
    logic [31:0] reg_mem [0:31];

    assign rs1_dat = (rs1_addr == 5'd0) ? 32'd0 : reg_mem[rs1_addr];
    assign rs2_dat = (rs2_addr == 5'd0) ? 32'd0 : reg_mem[rs2_addr];

    always_ff @(posedge clk) begin
        if (we && rd_addr != 5'd0) reg_mem[rd_addr] <= rd_dat;
    end
endmodule

// File: rtl/processor.sv
// Single-cycle RV32I-subset core: fetch, execute and retire one instruction per clk edge.
// Latency: 1 cycle per instruction. Backpressure: none; reset low blocks all writes.
// Ports: clk, rst (async active-low). All results live in internal state.
module processor
    import processor_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [31:0] pc, next_pc, pc_plus4, pc_target;
    logic [31:0] inst, imm, rs1_dat, rs2_dat;
    logic [31:0] alu_a, alu_b, alu_y, mem_rdat, rd_dat;
    logic        take_target;
    ctrl_t       ctrl;

    inst_mem #(.DEPTH(IMEM_DEPTH)) inst_mem_i (
        .clk       (clk),
        .addr      (pc[IAW+1:2]),
        .dat       (inst),
        .load_en   (1'b0),
        .load_addr ('0),
        .load_dat  (32'd0)
    );

    decoder decoder_i (
        .opcode (inst[6:0]),
        .funct3 (inst[14:12]),
        .funct7 (inst[31:25]),
        .ctrl   (ctrl)
    );

    imm_gen imm_gen_i (
        .inst (inst[31:7]),
        .sel  (ctrl.imm_sel),
        .imm  (imm)
    );

    // Writes are gated by rst so an instruction abandoned by reset leaves no trace.
    reg_file reg_file_i (
        .clk      (clk),
        .rs1_addr (inst[19:15]),
        .rs2_addr (inst[24:20]),
        .rs1_dat  (rs1_dat),
        .rs2_dat  (rs2_dat),
        .we       (ctrl.reg_we & rst),
        .rd_addr  (inst[11:7]),
        .rd_dat   (rd_dat)
    );

    assign alu_a = ctrl.a_pc  ? pc  : rs1_dat;
    assign alu_b = ctrl.b_imm ? imm : rs2_dat;

    alu alu_i (
        .a  (alu_a),
        .b  (alu_b),
        .op (ctrl.alu_op),
        .y  (alu_y)
    );

    // Load/store address is rs1+imm from the ALU; byte offset bits are dropped.
    data_mem #(.DEPTH(DMEM_DEPTH)) data_mem_i (
        .clk  (clk),
        .addr (alu_y[DAW+1:2]),
        .rdat (mem_rdat),
        .we   (ctrl.mem_we & rst),
        .wdat (rs2_dat)
    );

    assign pc_plus4    = pc + 32'd4;
    assign pc_target   = pc + imm;
    assign take_target = ctrl.jal | (ctrl.branch & branch_taken(inst[14:12], rs1_dat, rs2_dat));

    always_comb begin
        if (ctrl.jalr)        next_pc = alu_y & ~32'd1;
        else if (take_target) next_pc = pc_target;
        else                  next_pc = pc_plus4;
    end

    always_comb begin
        case (ctrl.wb_sel)
            WB_MEM:  rd_dat = mem_rdat;
            WB_PC4:  rd_dat = pc_plus4;
            default: rd_dat = alu_y;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= next_pc;
    end
endmodule

// File: tb/tb_processor.sv
module tb_processor;
    localparam int          DEPTH    = 256;
    localparam int          AW       = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk;
    logic rst;

    processor #(.IMEM_DEPTH(DEPTH), .DMEM_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction-set model state
    logic [31:0] m_reg  [32];
    logic [31:0] m_imem [DEPTH];
    logic [31:0] m_dmem [DEPTH];
    logic [31:0] m_pc;
    int checks;
    int passed;
    int cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0:    return alt ? x - y : x + y;
            3'd1:    return x << y[4:0];
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic void model_step();
        logic [31:0] in, a, b, immi, imms, immb, immu, immj, res, nxt, addr;
        logic [6:0]  op, f7;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        wr, tk;
        in   = m_imem[m_pc[AW+1:2]];
        op   = in[6:0];
        rd   = in[11:7];
        f3   = in[14:12];
        f7   = in[31:25];
        a    = m_reg[in[19:15]];
        b    = m_reg[in[24:20]];
        immi = {{20{in[31]}}, in[31:20]};
        imms = {{20{in[31]}}, in[31:25], in[11:7]};
        immb = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
        immu = {in[31:12], 12'd0};
        immj = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
        nxt  = m_pc + 32'd4;
        wr   = 1'b0;
        res  = 32'd0;
        case (op)
            7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                wr = 1'b1; res = alu_model(f3, f7 == 7'h20, a, b);
            end
            7'h13: if ((f3 != 3'd1 || f7 == 7'h00) &&
                       (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20)) begin
                wr = 1'b1; res = alu_model(f3, f3 == 3'd5 && f7 == 7'h20, a, immi);
            end
            7'h03: if (f3 == 3'd2) begin
                addr = a + immi; wr = 1'b1; res = m_dmem[addr[AW+1:2]];
            end
            7'h23: if (f3 == 3'd2) begin
                addr = a + imms; m_dmem[addr[AW+1:2]] = b;
            end
            7'h63: begin
                case (f3)
                    3'd0:    tk = (a == b);
                    3'd1:    tk = (a != b);
                    3'd4:    tk = $signed(a) < $signed(b);
                    3'd5:    tk = $signed(a) >= $signed(b);
                    3'd6:    tk = a < b;
                    3'd7:    tk = a >= b;
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = m_pc + immb;
            end
            7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + immj; end
            7'h67: if (f3 == 3'd0) begin
                wr = 1'b1; res = m_pc + 32'd4; nxt = (a + immi) & 32'hFFFF_FFFE;
            end
            7'h37: begin wr = 1'b1; res = immu; end
            7'h17: begin wr = 1'b1; res = m_pc + immu; end
            default: ;
        endcase
        if (wr && rd != 5'd0) m_reg[rd] = res;
        m_pc = nxt;
    endfunction

    // ---------------- the one compare routine ----------------
    task automatic compare_state(input string tag);
        int bad;
        chk($sformatf("%s pc", tag), dut.pc, m_pc);
        bad = -1;
        for (int i = 0; i < 32; i++)
            if (bad < 0 && dut.reg_file_i.reg_mem[i] !== m_reg[i]) bad = i;
        if (bad < 0) bad = 31;
        chk($sformatf("%s x%0d", tag, bad), dut.reg_file_i.reg_mem[bad], m_reg[bad]);
        bad = -1;
        for (int i = 0; i < DEPTH; i++)
            if (bad < 0 && dut.data_mem_i.mem[i] !== m_dmem[i]) bad = i;
        if (bad < 0) bad = DEPTH - 1;
        chk($sformatf("%s dmem[%0d]", tag, bad), dut.data_mem_i.mem[bad], m_dmem[bad]);
    endtask

    // ---------------- preload helpers (DUT + model together) ----------------
    task automatic put_reg(input int r, input logic [31:0] v);
        m_reg[r] = v;
        dut.reg_file_i.reg_mem[r] <= v;
    endtask
    task automatic put_imem(input int i, input logic [31:0] v);
        m_imem[i] = v;
        dut.inst_mem_i.mem[i] <= v;
    endtask
    task automatic put_dmem(input int i, input logic [31:0] v);
        m_dmem[i] = v;
        dut.data_mem_i.mem[i] <= v;
    endtask

    task automatic enter_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        m_pc = RESET_PC;
        for (int i = 0; i < 32; i++) put_reg(i, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            put_imem(i, NOP);
            put_dmem(i, 32'd0);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_step();
            @(negedge clk);
            cyc++;
            compare_state($sformatf("cyc%0d", cyc));
        end
    endtask

    // ---------------- random program generation ----------------
    function automatic logic [6:0] pick_f7();
        if ($urandom_range(0, 7) == 0) return 7'($urandom());
        return ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm12;
        rd    = 5'($urandom());
        rs1   = 5'($urandom());
        rs2   = 5'($urandom());
        f3    = 3'($urandom());
        imm12 = 12'($urandom());
        case ($urandom_range(0, 17))
            0, 1, 2, 3: return enc_r(pick_f7(), rs2, rs1, f3, rd, 7'h33);
            4, 5, 6, 7: begin
                if (f3 == 3'd1 || f3 == 3'd5) imm12 = {pick_f7(), imm12[4:0]};
                return enc_i(imm12, rs1, f3, rd, 7'h13);
            end
            8:  return enc_i(imm12, rs1, ($urandom_range(0, 5) == 0) ? f3 : 3'd2, rd, 7'h03);
            9:  return enc_s(imm12, rs2, rs1, ($urandom_range(0, 5) == 0) ? f3 : 3'd2);
            10, 11: return enc_b(13'($urandom()), rs2, rs1, f3);
            12: return enc_j(21'($urandom()), rd);
            13: return enc_i(imm12, rs1, ($urandom_range(0, 5) == 0) ? f3 : 3'd0, rd, 7'h67);
            14: return {20'($urandom()), rd, 7'h37};
            15: return {20'($urandom()), rd, 7'h17};
            16: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return 32'd0 - 32'($urandom_range(1, 40));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        checks = 0;
        passed = 0;
        cyc    = 0;
        rst    = 1'b1;
        #2 rst = 1'b0;
        #1 chk("reset pc", dut.pc, RESET_PC);

        // add x3,x4,x2
        enter_reset();
        put_reg(4, 32'd5);
        put_reg(2, 32'd7);
        put_imem(0, 32'h002201B3);
        release_reset();
        run(1);
        chk("add x3", dut.reg_file_i.reg_mem[3], 32'd12);
        chk("add pc", dut.pc, 32'd4);

        // addi x0,x0,5 ; sub x5,x1,x2
        enter_reset();
        put_reg(1, 32'd3);
        put_reg(2, 32'd5);
        put_imem(0, enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13));
        put_imem(1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33));
        release_reset();
        run(2);
        chk("x0 stays 0", dut.reg_file_i.reg_mem[0], 32'd0);
        chk("sub x5", dut.reg_file_i.reg_mem[5], 32'hFFFF_FFFE);

        // sw x2,8(x1) ; lw x3,8(x1)
        enter_reset();
        put_reg(1, 32'h0000_0040);
        put_reg(2, 32'hDEAD_BEEF);
        put_imem(0, enc_s(12'd8, 5'd2, 5'd1, 3'd2));
        put_imem(1, enc_i(12'd8, 5'd1, 3'd2, 5'd3, 7'h03));
        release_reset();
        run(2);
        chk("lw x3", dut.reg_file_i.reg_mem[3], 32'hDEAD_BEEF);
        chk("dmem[18]", dut.data_mem_i.mem[18], 32'hDEAD_BEEF);

        // beq taken / not taken
        enter_reset();
        put_reg(1, 32'd1);
        put_reg(2, 32'd1);
        put_imem(0, enc_b(13'd8, 5'd2, 5'd1, 3'd0));
        release_reset();
        run(1);
        chk("beq taken pc", dut.pc, 32'd8);
        enter_reset();
        put_reg(1, 32'd1);
        put_reg(2, 32'd2);
        put_imem(0, enc_b(13'd8, 5'd2, 5'd1, 3'd0));
        release_reset();
        run(1);
        chk("beq not taken pc", dut.pc, 32'd4);

        // nop ; jal x1,+16 ; undefined word at 20
        enter_reset();
        put_imem(1, enc_j(21'd16, 5'd1));
        put_imem(5, 32'hFFFF_FFFF);
        release_reset();
        run(2);
        chk("jal link x1", dut.reg_file_i.reg_mem[1], 32'd8);
        chk("jal pc", dut.pc, 32'd20);
        run(1);
        chk("undefined pc", dut.pc, 32'd24);
        chk("undefined x1 kept", dut.reg_file_i.reg_mem[1], 32'd8);

        // randomized programs
        for (int p = 0; p < 6; p++) begin
            enter_reset();
            for (int i = 0; i < DEPTH; i++) begin
                put_imem(i, rand_inst());
                put_dmem(i, $urandom());
            end
            for (int r = 1; r < 32; r++) put_reg(r, rand_val());
            release_reset();
            run(400);
        end

        // asynchronous reset between edges, mid-program
        for (int k = 0; k < 8 && m_pc == RESET_PC; k++) run(1);
        #2 rst = 1'b0;
        m_pc = RESET_PC;
        #1 chk("async reset pc", dut.pc, RESET_PC);
        compare_state("in reset");
        run(2);
        release_reset();
        run(20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_DEPTH, default 256, data memory depth in 32-bit words.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value while reset is asserted.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-006 SHALL have no other ports; results are observed through internal state only.

Function
REQ-007 SHALL be a single-cycle RV32I-subset core: one instruction fetched, executed and retired per clk rising edge.
REQ-008 SHALL fetch from word index pc[log2(IMEM_DEPTH)+1:2]; fetch is combinational; higher PC bits are ignored (wrap-around).
REQ-009 SHALL execute R-type: add, sub, and, or, xor, sll, srl, sra, slt, sltu.
REQ-010 SHALL execute I-type ALU: addi, andi, ori, xori, slli, srli, srai, slti, sltiu.
REQ-011 SHALL execute lw and sw, word-aligned only; address bits [1:0] are ignored; data index wraps modulo DMEM_DEPTH.
REQ-012 SHALL execute beq, bne, blt, bge, bltu, bgeu, jal, jalr, lui and auipc.
REQ-013 SHALL sign-extend immediates per RV32I formats (I, S, B, U, J); shifts use rs2/imm bits [4:0] only.
REQ-014 SHALL compute next PC as pc+4, or the branch/jal target (pc+imm) when taken, or (rs1+imm)&~1 for jalr; 32-bit arithmetic wraps.
REQ-015 SHALL write jal/jalr link value pc+4 to rd.
REQ-016 SHALL write rd on the clk rising edge ending the instruction; writes to x0 are discarded; x0 always reads 0.
REQ-017 SHALL read rs1/rs2 combinationally; a read of the register being written in the same cycle returns the old value.
REQ-018 SHALL treat any unsupported opcode or funct combination as a NOP: no register or memory write, PC advances by 4.
REQ-019 SHALL perform data memory reads combinationally and writes on the clk rising edge when sw executes.

Reset
REQ-020 SHALL force pc to RESET_PC immediately when rst goes low, independent of clk.
REQ-021 SHALL NOT reset register file, instruction memory or data memory contents; they hold preloaded values.
REQ-022 SHALL suppress register and memory writes while rst is low; the first instruction retires on the first clk rising edge after rst goes high.
REQ-023 SHALL, on reset asserted mid-program, abandon the current instruction with no partial write.

Structure
REQ-024 SHALL place opcode constants, funct3/funct7 constants and the ALU-operation enum in a shared package processor_pkg.
REQ-025 SHALL instantiate module inst_mem as instance inst_mem_i, with storage array mem (IMEM_DEPTH x 32 bits), loadable by $readmemb.
REQ-026 SHALL instantiate module reg_file as instance reg_file_i, with storage array reg_mem (32 x 32 bits, index = register number), loadable by $readmemb.
REQ-027 SHALL keep decoder, ALU, immediate generator and data memory as separate sub-modules; alu is the natural standalone unit.

Verification
REQ-028 SHALL pass: x4=5, x2=7, inst 0x002201B3 (add x3,x4,x2) at address 0, release rst -> x3=12 after first rising edge, pc=4.
REQ-029 SHALL pass: addi x0,x0,5 -> x0 reads 0; sub x5,x1,x2 with x1=3, x2=5 -> x5=0xFFFF_FFFE.
REQ-030 SHALL pass: x1=0x40, x2=0xDEADBEEF; sw x2,8(x1) then lw x3,8(x1) -> x3=0xDEADBEEF, data word 18 holds it.
REQ-031 SHALL pass: x1=x2=1, beq x1,x2,+8 at pc=0 -> next pc=8; with x2=2 -> next pc=4.
REQ-032 SHALL pass: jal x1,+16 at pc=4 -> x1=8, pc=20; undefined word 0xFFFFFFFF -> no writes, pc+4.
REQ-033 SHALL pass: rst driven low between clk edges mid-program -> pc=RESET_PC at once, register contents unchanged.
